// File: rtl/weight_load_scheduler_pkg.sv
// Shared definitions for the weight-load path: FSM encoding, default geometry
// and address-width derivation (also used by weight_bram_controller).
package weight_load_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WRST = 3'd1,
        ST_LOAD = 3'd2,
        ST_READ = 3'd3,
        ST_DONE = 3'd4
    } wls_state_e;

    localparam int unsigned DEF_AXIS_DATA_WIDTH = 64;
    localparam int unsigned DEF_BEATS_PER_LINE  = 18;   // 1152 / 64
    localparam int unsigned DEF_BRAM_DEPTH      = 512;

    // Width needed to index 'depth' entries, never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/weight_load_scheduler.sv
// Sequences one weight job: reset the BRAM write pointer, forward the DMA
// stream line by line, then serve kernel-pair reads for N passes.
module weight_load_scheduler
    import weight_load_scheduler_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
    parameter int unsigned BEATS_PER_LINE  = DEF_BEATS_PER_LINE,
    parameter int unsigned BRAM_DEPTH      = DEF_BRAM_DEPTH,
    localparam int unsigned ADDR_W         = addr_w(BRAM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [ADDR_W:0]            i_num_lines,
    input  logic [7:0]                 i_num_passes,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                       s_axis_tready,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                       m_axis_tready,
    output logic                       o_write_addr_rst,
    output logic                       o_read_en,
    output logic [ADDR_W-1:0]          o_read_addr,
    input  logic                       i_kernel_req,
    output logic                       o_kernel_valid,
    output logic                       o_kernel_last,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err_cfg,
    output logic                       o_err_tlast
);

    localparam int unsigned BEAT_W = addr_w(BEATS_PER_LINE);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    wls_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  line_q, line_d;
    logic [CNT_W-1:0]  lines_q, lines_d;
    logic [7:0]        passes_q, passes_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]        pass_q, pass_d;
    logic              issued_q, issued_d;
    logic              read_en_q, read_en_d;
    logic [ADDR_W-1:0] read_addr_q, read_addr_d;
    logic              read_last_q, read_last_d;
    logic              kvalid_q, kvalid_d;
    logic              klast_q, klast_d;
    logic              err_tlast_q, err_tlast_d;
    logic              err_cfg_q, err_cfg_d;

    logic [CNT_W-1:0] lines_m1;
    logic             beat_end, line_end, rd_end, last_pass, beat_acc, cfg_ok;

    assign lines_m1  = lines_q - CNT_W'(1);
    assign beat_end  = (beat_q == BEAT_W'(BEATS_PER_LINE - 1));
    assign line_end  = (line_q == lines_m1);
    assign rd_end    = ({1'b0, rd_idx_q} == lines_m1);
    assign last_pass = (pass_q == passes_q - 8'd1);
    assign beat_acc  = s_axis_tvalid & m_axis_tready;
    assign cfg_ok    = (i_num_lines != '0) && (i_num_lines <= CNT_W'(BRAM_DEPTH));

    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        line_d           = line_q;
        lines_d          = lines_q;
        passes_d         = passes_q;
        rd_idx_d         = rd_idx_q;
        pass_d           = pass_q;
        issued_d         = issued_q;
        read_addr_d      = read_addr_q;
        err_tlast_d      = err_tlast_q;
        read_en_d        = 1'b0;
        read_last_d      = 1'b0;
        kvalid_d         = read_en_q;
        klast_d          = read_en_q & read_last_q;
        err_cfg_d        = 1'b0;
        s_axis_tready    = 1'b0;
        m_axis_tvalid    = 1'b0;
        m_axis_tlast     = 1'b0;
        m_axis_tdata     = '0;
        o_write_addr_rst = 1'b0;
        o_done           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (cfg_ok) begin
                        lines_d     = i_num_lines;
                        passes_d    = (i_num_passes == 8'd0) ? 8'd1 : i_num_passes;
                        err_tlast_d = 1'b0;
                        beat_d      = '0;
                        line_d      = '0;
                        rd_idx_d    = '0;
                        pass_d      = '0;
                        issued_d    = 1'b0;
                        state_d     = ST_WRST;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            ST_WRST: begin
                o_write_addr_rst = 1'b1;
                state_d          = ST_LOAD;
            end
            ST_LOAD: begin
                m_axis_tdata = s_axis_tdata;
                m_axis_tlast = s_axis_tlast;
                // Abort suppresses the handshake so no beat lands in a cancelled job.
                if (!i_abort) begin
                    m_axis_tvalid = s_axis_tvalid;
                    s_axis_tready = m_axis_tready;
                    if (beat_acc) begin
                        if (s_axis_tlast != beat_end)
                            err_tlast_d = 1'b1;
                        if (beat_end) begin
                            beat_d = '0;
                            if (line_end) begin
                                line_d  = '0;
                                state_d = ST_READ;
                            end else begin
                                line_d = line_q + CNT_W'(1);
                            end
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
            end
            ST_READ: begin
                if (i_kernel_req && !issued_q) begin
                    read_en_d   = 1'b1;
                    read_addr_d = rd_idx_q;
                    read_last_d = rd_end & last_pass;
                    if (rd_end) begin
                        rd_idx_d = '0;
                        if (last_pass) issued_d = 1'b1;
                        else           pass_d   = pass_q + 8'd1;
                    end else begin
                        rd_idx_d = rd_idx_q + ADDR_W'(1);
                    end
                end
                if (kvalid_q && klast_q)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            read_en_d   = 1'b0;
            read_last_d = 1'b0;
            read_addr_d = read_addr_q;
            kvalid_d    = 1'b0;
            klast_d     = 1'b0;
            o_done      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            line_q      <= '0;
            lines_q     <= '0;
            passes_q    <= '0;
            rd_idx_q    <= '0;
            pass_q      <= '0;
            issued_q    <= 1'b0;
            read_en_q   <= 1'b0;
            read_addr_q <= '0;
            read_last_q <= 1'b0;
            kvalid_q    <= 1'b0;
            klast_q     <= 1'b0;
            err_tlast_q <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            lines_q     <= lines_d;
            passes_q    <= passes_d;
            rd_idx_q    <= rd_idx_d;
            pass_q      <= pass_d;
            issued_q    <= issued_d;
            read_en_q   <= read_en_d;
            read_addr_q <= read_addr_d;
            read_last_q <= read_last_d;
            kvalid_q    <= kvalid_d;
            klast_q     <= klast_d;
            err_tlast_q <= err_tlast_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    assign o_read_en      = read_en_q;
    assign o_read_addr    = read_addr_q;
    assign o_kernel_valid = kvalid_q;
    assign o_kernel_last  = klast_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_err_cfg      = err_cfg_q;
    assign o_err_tlast    = err_tlast_q;

endmodule

// File: tb/tb_weight_load_scheduler.sv
// Directed bench for weight_load_scheduler: job-level reference model with
// per-cycle comparison plus literal expectations for each scenario.
module tb_weight_load_scheduler;

    localparam int DW    = 64;
    localparam int BPL   = 18;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0, i_abort = 1'b0;
    logic [AW:0]   i_num_lines = '0;
    logic [7:0]    i_num_passes = '0;
    logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tready;
    logic          m_axis_tvalid, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tready = 1'b1;
    logic          o_write_addr_rst, o_read_en;
    logic [AW-1:0] o_read_addr;
    logic          i_kernel_req = 1'b0;
    logic          o_kernel_valid, o_kernel_last, o_busy, o_done, o_err_cfg, o_err_tlast;

    always #5 clk = ~clk;

    weight_load_scheduler #(.AXIS_DATA_WIDTH(DW), .BEATS_PER_LINE(BPL), .BRAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_num_lines(i_num_lines), .i_num_passes(i_num_passes),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .s_axis_tready(s_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tready(m_axis_tready),
        .o_write_addr_rst(o_write_addr_rst), .o_read_en(o_read_en), .o_read_addr(o_read_addr),
        .i_kernel_req(i_kernel_req), .o_kernel_valid(o_kernel_valid), .o_kernel_last(o_kernel_last),
        .o_busy(o_busy), .o_done(o_done), .o_err_cfg(o_err_cfg), .o_err_tlast(o_err_tlast)
    );

    // ---------------- job-level reference model ----------------
    // phase: 0 idle, 1 write-pointer reset, 2 load, 3 read, 4 done
    typedef struct { int due; int addr; bit last; } item_t;
    item_t rq[$];
    item_t kq[$];
    int ph = 0, m_lines = 0, m_passes = 0, m_acc = 0, m_iss = 0;
    int m_done_edge = -1, m_cfg_edge = -1, m_raddr = 0, cyc = 0;
    bit m_err = 1'b0, m_lst = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; m_err = 1'b0; m_raddr = 0; m_acc = 0; m_iss = 0;
            m_done_edge = -1; m_cfg_edge = -1;
            rq.delete(); kq.delete();
        end else begin
            cyc++;
            while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
            while (kq.size() > 0 && kq[0].due < cyc) void'(kq.pop_front());
            if (i_abort && ph != 0) begin
                ph = 0; m_done_edge = -1;
                rq.delete(); kq.delete();
            end else begin
                case (ph)
                    0: if (i_start) begin
                        if (i_num_lines >= 1 && i_num_lines <= DEPTH) begin
                            m_lines = int'(i_num_lines);
                            m_passes = (i_num_passes == 0) ? 1 : int'(i_num_passes);
                            m_err = 1'b0; m_acc = 0; m_iss = 0; ph = 1;
                        end else m_cfg_edge = cyc;
                    end
                    1: ph = 2;
                    2: if (s_axis_tvalid && m_axis_tready) begin
                        if (s_axis_tlast != ((m_acc % BPL) == BPL - 1)) m_err = 1'b1;
                        m_acc++;
                        if (m_acc == m_lines * BPL) ph = 3;
                    end
                    3: if (cyc == m_done_edge) ph = 4;
                       else if (i_kernel_req && m_iss < m_lines * m_passes) begin
                        m_lst = (m_iss == m_lines * m_passes - 1);
                        m_raddr = m_iss % m_lines;
                        rq.push_back('{cyc, m_raddr, m_lst});
                        kq.push_back('{cyc + 1, m_raddr, m_lst});
                        if (m_lst) m_done_edge = cyc + 2;
                        m_iss++;
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    int chk_n = 0, pass_n = 0;
    int n_wrst = 0, n_fwd = 0, n_done = 0;
    bit hs = 1'b0;
    int addr_log[$];
    bit kl_log[$];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        chk_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    endtask

    task automatic compare_cycle();
        bit rv, kv, kl;
        rv = 1'b0; kv = 1'b0; kl = 1'b0;
        foreach (rq[i]) if (rq[i].due == cyc) rv = 1'b1;
        foreach (kq[i]) if (kq[i].due == cyc) begin kv = 1'b1; kl = kq[i].last; end
        check("busy", o_busy, ph != 0);
        check("write_addr_rst", o_write_addr_rst, ph == 1);
        check("done", o_done, ph == 4 && !i_abort);
        if (!i_abort) begin
            check("s_tready", s_axis_tready, ph == 2 && m_axis_tready);
            check("m_tvalid", m_axis_tvalid, ph == 2 && s_axis_tvalid);
        end
        if (ph == 2) begin
            check("m_tdata", m_axis_tdata, s_axis_tdata);
            check("m_tlast", m_axis_tlast, s_axis_tlast);
        end
        check("read_en", o_read_en, rv);
        check("read_addr", o_read_addr, m_raddr);
        check("kernel_valid", o_kernel_valid, kv);
        check("kernel_last", o_kernel_last, kl);
        check("err_cfg", o_err_cfg, m_cfg_edge == cyc);
        check("err_tlast", o_err_tlast, m_err);
        hs = s_axis_tvalid && s_axis_tready;
        if (o_write_addr_rst) n_wrst++;
        if (hs) n_fwd++;
        if (o_done) n_done++;
        if (o_read_en) addr_log.push_back(int'(o_read_addr));
        if (o_kernel_valid) kl_log.push_back(o_kernel_last);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_beats(input int n, input int la, input int lb, input bit stall);
        int guard;
        for (int i = 0; i < n; i++) begin
            if (stall && i == 5) begin
                m_axis_tready = 1'b0; ticks(2); m_axis_tready = 1'b1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tlast  = (i == la || i == lb);
            guard = 0;
            do begin tick(); guard++; end while (!hs && guard < 50);
            if (guard >= 50) begin check("beat_timeout", 1'b1, 1'b0); break; end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic start_job(input int lines, input int passes);
        i_num_lines = 10'(lines); i_num_passes = 8'(passes);
        i_start = 1'b1; tick(); i_start = 1'b0;
    endtask

    int bw, bf, bd, ba, bk;

    initial begin
        ticks(3);
        check("rst_busy", o_busy, 1'b0);
        check("rst_read_addr", o_read_addr, '0);
        rst_n = 1'b1;
        tick();

        // Two lines, one pass, backpressure inside line 0.
        bw = n_wrst; bf = n_fwd;
        start_job(2, 1);
        send_beats(36, 17, 35, 1'b1);
        check("t1_tready_after_load", s_axis_tready, 1'b0);
        check("t1_wrst_pulses", n_wrst - bw, 1);
        check("t1_beats_fwd", n_fwd - bf, 36);
        check("t1_err_tlast", o_err_tlast, 1'b0);
        ba = addr_log.size(); bk = kl_log.size(); bd = n_done;
        i_kernel_req = 1'b1; ticks(3); i_kernel_req = 1'b0; ticks(6);
        check("t1_reads", addr_log.size() - ba, 2);
        check("t1_addr0", addr_log[ba], 0);
        check("t1_addr1", addr_log[ba + 1], 1);
        check("t1_valids", kl_log.size() - bk, 2);
        check("t1_last_pattern", {kl_log[bk], kl_log[bk + 1]}, 2'b01);
        check("t1_done", n_done - bd, 1);

        // One line, three passes, continuous requests.
        start_job(1, 3);
        send_beats(18, 17, -1, 1'b0);
        ba = addr_log.size(); bk = kl_log.size(); bd = n_done;
        i_kernel_req = 1'b1; ticks(5); i_kernel_req = 1'b0; ticks(5);
        check("t2_reads", addr_log.size() - ba, 3);
        check("t2_addrs", addr_log[ba] + addr_log[ba + 1] + addr_log[ba + 2], 0);
        check("t2_last_pattern", {kl_log[bk], kl_log[bk + 1], kl_log[bk + 2]}, 3'b001);
        check("t2_done", n_done - bd, 1);

        // Stray tlast on beat 10; passes=0 runs as one pass.
        bf = n_fwd;
        start_job(1, 0);
        send_beats(18, 10, 17, 1'b0);
        check("t3_err_tlast_set", o_err_tlast, 1'b1);
        check("t3_beats_fwd", n_fwd - bf, 18);
        check("t3_in_read", o_busy, 1'b1);
        bd = n_done;
        i_kernel_req = 1'b1; ticks(2); i_kernel_req = 1'b0; ticks(5);
        check("t3_done", n_done - bd, 1);

        // Bad configurations.
        start_job(0, 1);
        check("cfg0_pulse", o_err_cfg, 1'b1);
        check("cfg0_busy", o_busy, 1'b0);
        tick();
        check("cfg0_pulse_end", o_err_cfg, 1'b0);
        start_job(513, 1);
        check("cfg513_pulse", o_err_cfg, 1'b1);
        check("cfg513_busy", o_busy, 1'b0);
        check("cfg_keeps_err_tlast", o_err_tlast, 1'b1);
        tick();

        // Accepted start clears the flag; abort at beat 7 of the load.
        bf = n_fwd; bd = n_done;
        start_job(1, 1);
        check("t4_err_cleared", o_err_tlast, 1'b0);
        send_beats(7, -1, -1, 1'b0);
        s_axis_tvalid = 1'b1; i_abort = 1'b1; tick();
        i_abort = 1'b0; s_axis_tvalid = 1'b0;
        check("t4_abort_busy", o_busy, 1'b0);
        check("t4_abort_tready", s_axis_tready, 1'b0);
        check("t4_beats_fwd", n_fwd - bf, 7);
        ticks(3);
        check("t4_no_done", n_done - bd, 0);

        // Start while busy ignored; reset mid-read.
        bf = n_fwd; bd = n_done;
        start_job(1, 2);
        i_num_lines = 10'd2; i_start = 1'b1; tick(); i_start = 1'b0;
        send_beats(18, 17, -1, 1'b0);
        check("t5_load_len_kept", n_fwd - bf, 18);
        check("t5_in_read", o_busy, 1'b1);
        i_kernel_req = 1'b1; tick(); i_kernel_req = 1'b0;
        check("t5_read_en", o_read_en, 1'b1);
        rst_n = 1'b0; #1;
        check("t5_rst_busy", o_busy, 1'b0);
        check("t5_rst_read_en", o_read_en, 1'b0);
        check("t5_rst_read_addr", o_read_addr, '0);
        ticks(2);
        check("t5_rst_kvalid", o_kernel_valid, 1'b0);
        rst_n = 1'b1;
        ticks(4);
        check("t5_no_done", n_done - bd, 0);
        check("t5_idle", o_busy, 1'b0);

        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule

// File: doc/weight_load_scheduler.md
WEIGHT_LOAD_SCHEDULER -- requirements
Module: weight_load_scheduler

Interface
REQ-001 SHALL expose parameter AXIS_DATA_WIDTH, default 64, stream beat width.
REQ-002 SHALL expose parameter BEATS_PER_LINE, default 18, beats per BRAM line (1152/64).
REQ-003 SHALL expose parameter BRAM_DEPTH, default 512, weight BRAM lines; ADDR_W = clog2(BRAM_DEPTH).
REQ-004 SHALL have ports:
  clk  in  1  single clock, all logic rising-edge;
  rst_n  in  1  asynchronous, active-low reset;
  i_start  in  1  one-cycle job start;
  i_abort  in  1  synchronous job cancel;
  i_num_lines  in  ADDR_W+1  kernel-pair lines to load, valid range 1..BRAM_DEPTH;
  i_num_passes  in  8  read sweeps over loaded lines, 0 treated as 1;
  s_axis_tvalid/s_axis_tlast  in  1  upstream DMA stream;
  s_axis_tdata  in  AXIS_DATA_WIDTH  upstream data;
  s_axis_tready  out  1  upstream ready;
  m_axis_tvalid/m_axis_tlast  out  1  stream to weight BRAM controller;
  m_axis_tdata  out  AXIS_DATA_WIDTH  data to weight BRAM controller;
  m_axis_tready  in  1  BRAM controller ready;
  o_write_addr_rst  out  1  BRAM write-pointer reset pulse;
  o_read_en  out  1  BRAM read enable;
  o_read_addr  out  ADDR_W  BRAM read line;
  i_kernel_req  in  1  compute engine requests next kernel pair;
  o_kernel_valid  out  1  kernel A/B outputs of BRAM valid this cycle;
  o_kernel_last  out  1  final pair of final pass;
  o_busy  out  1  state != IDLE;
  o_done  out  1  one-cycle job-complete pulse;
  o_err_cfg  out  1  one-cycle bad-config pulse;
  o_err_tlast  out  1  sticky tlast-misalignment flag, cleared on accepted start.

Function
REQ-005 SHALL implement FSM IDLE -> WRST -> LOAD -> READ -> DONE -> IDLE.
REQ-006 IDLE: s_axis_tready=0, m_axis_tvalid=0; i_start with i_num_lines in 1..BRAM_DEPTH latches i_num_lines/i_num_passes, clears o_err_tlast, enters WRST; out-of-range -> o_err_cfg pulse next cycle, stay IDLE.
REQ-007 WRST: o_write_addr_rst=1 for exactly one cycle, then LOAD.
REQ-008 LOAD: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, tdata/tlast combinational pass-through; beat counts only on s_axis_tvalid&&m_axis_tready.
REQ-009 Beat counter 0..BEATS_PER_LINE-1 wraps; line counter increments on wrap; line boundaries derive from beat count, never tlast.
REQ-010 Accepted beat with tlast != (beat==BEATS_PER_LINE-1) SHALL set o_err_tlast; loading continues.
REQ-011 On acceptance of final beat of line i_num_lines-1: s_axis_tready=0 from next cycle, enter READ.
REQ-012 READ: i_kernel_req at cycle N -> o_read_en=1, o_read_addr=rd_idx at N+1 (registered) -> o_kernel_valid=1 at N+2; back-to-back requests sustain one pair per cycle.
REQ-013 rd_idx SHALL wrap from i_num_lines-1 to 0, incrementing pass counter; o_kernel_last accompanies o_kernel_valid for rd_idx=i_num_lines-1 on last pass.
REQ-014 After last request issued, i_kernel_req ignored; state enters DONE when last o_kernel_valid asserts; DONE pulses o_done one cycle, returns IDLE.
REQ-015 i_start while o_busy SHALL be ignored.
REQ-016 i_abort in any non-IDLE state: next cycle IDLE, tready/tvalid/read_en/kernel_valid 0, in-flight valid squashed, no o_done; abort wins over simultaneous start/req/beat.
REQ-017 o_read_en=0 and o_read_addr holds last value outside issued reads.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, all counters 0, every output 0 (o_read_addr=0, o_err_tlast=0).
REQ-019 Reset mid-LOAD or mid-READ SHALL discard the job; no o_done, no pulse on release.

Structure
REQ-020 Shared package SHALL hold FSM state encoding, BEATS_PER_LINE/BRAM_DEPTH defaults and ADDR_W derivation, shared with weight_bram_controller.
REQ-021 Single module, no sub-modules; beat/line/pass counters inline.

Verification
REQ-022 Start, num_lines=2, passes=1, 36 beats tlast at 18/36 -> one write_addr_rst pulse, 36 beats forwarded, tready low after beat 36, o_err_tlast=0.
REQ-023 Then i_kernel_req held 3 cycles -> read_addr 0,1 at N+1,N+2; kernel_valid at N+2,N+3; last at N+3; o_done at N+3 or N+4, third req ignored.
REQ-024 num_lines=1, passes=3, continuous req -> read_addr 0,0,0; only third valid carries last.
REQ-025 tlast on beat 10 of line 0 -> o_err_tlast set, load still completes at 18 beats per line; cleared by next accepted start.
REQ-026 num_lines=0 and 513 -> o_err_cfg pulse, o_busy stays 0; start while busy ignored.
REQ-027 i_abort mid-LOAD (beat 7) and rst_n low mid-READ -> IDLE next cycle/immediately, outputs 0, no o_done.
